// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Sequences instruction fetch from a byte-addressed, little-endian instruction
// memory. Words are captured into a 2-entry buffer and handed to decode.
// Taken branches flush the buffer and redirect the fetch address. Fetching
// halts on running past the end of memory or on a misaligned redirect target.
//
// Handshake: Fetch_Valid means the buffer head (Fetch_Instr/Fetch_PC) holds a
// word. A transfer happens on a rising clk edge where Fetch_Valid and
// Fetch_Ready are both 1. Fetch_Valid never depends combinationally on
// Fetch_Ready. A redirect in the same cycle cancels the transfer.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   Enable        permits new fetches; buffered words drain regardless
//   Instr_Addr    registered byte address to instruction memory
//   Instruction   memory read data for Instr_Addr (same cycle)
//   Branch_Taken  one-cycle redirect request
//   Branch_Target redirect address
//   Fetch_Valid   buffer head is valid
//   Fetch_Ready   decode accepts the head
//   Fetch_Instr   head instruction
//   Fetch_PC      head instruction address
//   Halted        in HALT with the buffer empty
//   Misaligned    sticky: a redirect target had nonzero low bits
//   dbg_state_o   current FSM state (IDLE=0, FETCH=1, HALT=2)
//   dbg_count_o   current buffer occupancy
// ---------------------------------------------------------------------------
module fetch_controller #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_LAST  = 200,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  output logic [63:0] Instr_Addr,
  input  logic [31:0] Instruction,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic        Fetch_Valid,
  input  logic        Fetch_Ready,
  output logic [31:0] Fetch_Instr,
  output logic [63:0] Fetch_PC,
  output logic        Halted,
  output logic        Misaligned,
  output logic [1:0]  dbg_state_o,
  output logic [1:0]  dbg_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  count_q, count_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] buf_instr_q [FIFO_DEPTH];
  logic [31:0] buf_instr_d [FIFO_DEPTH];
  logic [63:0] buf_pc_q [FIFO_DEPTH];
  logic [63:0] buf_pc_d [FIFO_DEPTH];
  logic [31:0] head_instr_q, head_instr_d;
  logic [63:0] head_pc_q, head_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;

  // Range checks use 65 bits so an address near the top of the 64-bit space
  // cannot wrap around and look fetchable.
  logic [64:0] addr_end;
  logic [64:0] tgt_end;
  logic        in_range;
  logic        tgt_in_range;
  logic        pop;
  logic        capture;

  assign addr_end     = {1'b0, addr_q} + 65'd3;
  assign tgt_end      = {1'b0, Branch_Target} + 65'd3;
  assign in_range     = (addr_end <= 65'(IMEM_LAST));
  assign tgt_in_range = (tgt_end <= 65'(IMEM_LAST));

  // A redirect wins over everything: no pop and no capture in its cycle.
  assign pop     = valid_q & Fetch_Ready & ~Branch_Taken;
  assign capture = (state_q == S_FETCH) & Enable & in_range &
                   ((count_q != 2'd2) | pop) & ~Branch_Taken;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    mis_d       = mis_q;

    if (Branch_Taken) begin
      count_d = 2'd0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      addr_d  = Branch_Target;
      if (Branch_Target[1:0] != 2'b00) begin
        state_d = S_HALT;
        mis_d   = 1'b1;
      end else if (!tgt_in_range) begin
        state_d = S_HALT;
      end else if (state_q == S_IDLE) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      if (pop) begin
        rd_d = ~rd_q;
      end
      if (capture) begin
        buf_instr_d[wr_q] = Instruction;
        buf_pc_d[wr_q]    = addr_q;
        wr_d              = ~wr_q;
        addr_d            = addr_q + 64'd4;
      end
      case ({capture, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      case (state_q)
        S_IDLE:  if (Enable) state_d = S_FETCH;
        S_FETCH: if (!in_range) state_d = S_HALT;
        default: state_d = state_q;
      endcase
    end

    // Head outputs are registered and hold their last value when empty.
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    if (count_d != 2'd0) begin
      head_instr_d = buf_instr_d[rd_d];
      head_pc_d    = buf_pc_d[rd_d];
    end
    valid_d  = (count_d != 2'd0);
    halted_d = (state_d == S_HALT) && (count_d == 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= RESET_PC;
      count_q      <= 2'd0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr_q[i] <= 32'd0;
        buf_pc_q[i]    <= 64'd0;
      end
      head_instr_q <= 32'd0;
      head_pc_q    <= 64'd0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      mis_q        <= mis_d;
    end
  end

  assign Instr_Addr  = addr_q;
  assign Fetch_Valid = valid_q;
  assign Fetch_Instr = head_instr_q;
  assign Fetch_PC    = head_pc_q;
  assign Halted      = halted_q;
  assign Misaligned  = mis_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//
// Drives fetch_controller against a byte-array instruction memory and checks
// it against a behavioural model: a fetch address, a queue of buffered PCs
// and a mode (idle / fetching / halted) updated once per clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

  localparam int unsigned IMEM_LAST = 200;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        en = 1'b0;
  logic [63:0] instr_addr;
  logic [31:0] instruction;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic        halted;
  logic        misaligned;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  fetch_controller #(
    .RESET_PC   (64'd0),
    .IMEM_LAST  (IMEM_LAST),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .Enable        (en),
    .Instr_Addr    (instr_addr),
    .Instruction   (instruction),
    .Branch_Taken  (branch_taken),
    .Branch_Target (branch_target),
    .Fetch_Valid   (fetch_valid),
    .Fetch_Ready   (fetch_ready),
    .Fetch_Instr   (fetch_instr),
    .Fetch_PC      (fetch_pc),
    .Halted        (halted),
    .Misaligned    (misaligned),
    .dbg_state_o   (dbg_state),
    .dbg_count_o   (dbg_count)
  );

  // instruction memory: little-endian bytes
  logic [7:0] imem [256];

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [7:0] b;
    if (a > 64'd252) return 32'd0;
    b = a[7:0];
    return {imem[b + 8'd3], imem[b + 8'd2], imem[b + 8'd1], imem[b]};
  endfunction

  always_comb instruction = word_at(instr_addr);

  // scoreboard / model
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_addr;
  int          m_mode;
  bit          m_mis;

  function automatic bit fits(input logic [63:0] a);
    return ({1'b0, a} + 65'd3) <= 65'(IMEM_LAST);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr = 64'd0;
    m_mode = M_IDLE;
    m_mis  = 1'b0;
  endtask

  // One clock edge of the model, using the inputs held during the cycle.
  task automatic model_edge();
    bit popped;
    if (branch_taken) begin
      exp_q.delete();
      m_addr = branch_target;
      if (branch_target[1:0] != 2'b00) begin
        m_mode = M_HALT;
        m_mis  = 1'b1;
      end else if (!fits(branch_target)) m_mode = M_HALT;
      else if (m_mode != M_IDLE) m_mode = M_FETCH;
    end else begin
      popped = (exp_q.size() != 0) && fetch_ready;
      if (popped) void'(exp_q.pop_front());
      if (m_mode == M_IDLE) begin
        if (en) m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
        if (!fits(m_addr)) m_mode = M_HALT;
        else if (en && (exp_q.size() < 2)) begin
          exp_q.push_back(m_addr);
          m_addr = m_addr + 64'd4;
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    fetch_ready = 1'b0;
    branch_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    branch_taken = 1'b1;
    branch_target = tgt;
    tick();
    branch_taken = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    #2;
    n_tests++;
    if (instr_addr !== 64'd0 || fetch_valid !== 1'b0 || fetch_instr !== 32'd0 ||
        fetch_pc !== 64'd0 || halted !== 1'b0 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0h valid=%0b instr=%0h pc=%0h halted=%0b mis=%0b, want all 0",
               instr_addr, fetch_valid, fetch_instr, fetch_pc, halted, misaligned);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_w;
    do_reset();
    en = 1'b1;
    fetch_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 38; k++) begin
      n_tests++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 64'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_pc k=%0d: got valid=%0b pc=%0d, want valid=1 pc=%0d",
                 k, fetch_valid, fetch_pc, 4 * k);
      end
      if (k == 0 || k == 20) begin
        exp_w = (k == 0) ? 32'h00700213 : 32'h04b35463;
        n_tests++;
        if (fetch_instr !== exp_w) begin
          n_fail++;
          $display("FAIL stream_instr pc=%0d: got %08h, want %08h", 4 * k, fetch_instr, exp_w);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1;
    fetch_ready = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (dbg_count !== 2'd2 || instr_addr !== 64'd8 || fetch_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL backpressure_hold: count=%0d addr=%0d pc=%0d, want count=2 addr=8 pc=0",
               dbg_count, instr_addr, fetch_pc);
    end
    fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 64'(4 * k)) begin
        n_fail++;
        $display("FAIL backpressure_drain k=%0d: got valid=%0b pc=%0d, want valid=1 pc=%0d",
                 k, fetch_valid, fetch_pc, 4 * k);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    bit found = 1'b0;
    do_reset();
    en = 1'b1;
    fetch_ready = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      if (fetch_valid === 1'b1 && fetch_pc === 64'd140) found = 1'b1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL redirect_reach140: head pc=%0d, want 140 within 60 cycles", fetch_pc);
    end
    fetch_ready = 1'b0;
    tick();
    n_tests++;
    if (dbg_count !== 2'd2 || fetch_pc !== 64'd140) begin
      n_fail++;
      $display("FAIL redirect_full: count=%0d pc=%0d, want count=2 pc=140", dbg_count, fetch_pc);
    end
    fetch_ready = 1'b1;
    redirect(64'd56);
    n_tests++;
    if (fetch_valid !== 1'b0 || instr_addr !== 64'd56 || dbg_count !== 2'd0) begin
      n_fail++;
      $display("FAIL redirect_flush: valid=%0b addr=%0d count=%0d, want valid=0 addr=56 count=0",
               fetch_valid, instr_addr, dbg_count);
    end
    tick();
    n_tests++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 64'd56 || fetch_instr !== 32'h0162a423) begin
      n_fail++;
      $display("FAIL redirect_target: valid=%0b pc=%0d instr=%08h, want valid=1 pc=56 instr=0162a423",
               fetch_valid, fetch_pc, fetch_instr);
    end
  endtask

  task automatic test_end_of_mem();
    logic [63:0] last = 64'd0;
    bit          seen = 1'b0;
    fetch_ready = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (fetch_valid === 1'b1) last = fetch_pc;
      if (halted === 1'b1) seen = 1'b1;
      else tick();
    end
    n_tests++;
    if (!seen || last !== 64'd196 || instr_addr !== 64'd200) begin
      n_fail++;
      $display("FAIL end_of_mem: halted=%0b last_pc=%0d addr=%0d, want halted=1 last_pc=196 addr=200",
               halted, last, instr_addr);
    end
    redirect(64'd0);
    n_tests++;
    if (halted !== 1'b0 || instr_addr !== 64'd0) begin
      n_fail++;
      $display("FAIL end_resume: halted=%0b addr=%0d, want halted=0 addr=0", halted, instr_addr);
    end
    tick();
    n_tests++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL end_resume_fetch: valid=%0b pc=%0d, want valid=1 pc=0", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_misaligned();
    redirect(64'h52);
    tick();
    n_tests++;
    if (misaligned !== 1'b1 || halted !== 1'b1 || fetch_valid !== 1'b0 || instr_addr !== 64'h52) begin
      n_fail++;
      $display("FAIL misaligned_halt: mis=%0b halted=%0b valid=%0b addr=%0h, want 1 1 0 52",
               misaligned, halted, fetch_valid, instr_addr);
    end
    redirect(64'd8);
    tick();
    n_tests++;
    if (misaligned !== 1'b1 || halted !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 64'd8) begin
      n_fail++;
      $display("FAIL misaligned_sticky: mis=%0b halted=%0b valid=%0b pc=%0d, want 1 0 1 8",
               misaligned, halted, fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    en = 1'b1;
    fetch_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (dbg_count !== 2'd2) begin
      n_fail++;
      $display("FAIL midreset_setup: count=%0d, want 2", dbg_count);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (fetch_valid !== 1'b0 || instr_addr !== 64'd0 || fetch_pc !== 64'd0 ||
        fetch_instr !== 32'd0 || halted !== 1'b0 || misaligned !== 1'b0 || dbg_count !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_async: valid=%0b addr=%0d pc=%0d instr=%0h halted=%0b mis=%0b count=%0d, want all 0",
               fetch_valid, instr_addr, fetch_pc, fetch_instr, halted, misaligned, dbg_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_restart: valid=%0b pc=%0d, want valid=1 pc=0", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 99) < 80);
      fetch_ready = ($urandom_range(0, 99) < 70);
      branch_taken = ($urandom_range(0, 99) < 5);
      r = $urandom_range(0, 99);
      if (r < 3) branch_target = 64'($urandom_range(0, 50) * 4 + $urandom_range(1, 3));
      else if (r < 18) branch_target = 64'(204 + $urandom_range(0, 10) * 4);
      else branch_target = 64'($urandom_range(0, 50) * 4);
      tick();
      n_tests++;
      if (instr_addr !== m_addr || halted !== (m_mode == M_HALT && exp_q.size() == 0) ||
          misaligned !== m_mis || fetch_valid !== (exp_q.size() != 0) ||
          dbg_count !== 2'(exp_q.size())) begin
        n_fail++;
        $display("FAIL random_ctrl c=%0d: addr=%0d halted=%0b mis=%0b valid=%0b count=%0d, want addr=%0d mode=%0d mis=%0b count=%0d",
                 c, instr_addr, halted, misaligned, fetch_valid, dbg_count, m_addr, m_mode, m_mis, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_tests++;
        if (fetch_pc !== exp_q[0] || fetch_instr !== word_at(exp_q[0])) begin
          n_fail++;
          $display("FAIL random_head c=%0d: pc=%0d instr=%08h, want pc=%0d instr=%08h",
                   c, fetch_pc, fetch_instr, exp_q[0], word_at(exp_q[0]));
        end
      end
    end
    branch_taken = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) imem[i] = 8'd0;
    for (int i = 0; i < 38; i++) begin
      w = $urandom;
      if (i == 0)  w = 32'h00700213;
      if (i == 14) w = 32'h0162a423;
      if (i == 20) w = 32'h04b35463;
      imem[4 * i]     = w[7:0];
      imem[4 * i + 1] = w[15:8];
      imem[4 * i + 2] = w[23:16];
      imem[4 * i + 3] = w[31:24];
    end
    model_reset();

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_end_of_mem();
    test_misaligned();
    test_reset_midstream();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
